// File: rtl/fixed_point_mul_arbiter.sv
// Round-robin front end that shares one fixed-point multiplier between NUM_REQ clients.
// ABS requests are issued as A*(+/-1.0) so every operation has identical latency and ordering.
module fixed_point_mul_arbiter #(
    parameter int WIDTH       = 8,
    parameter int FRAC_BITS   = 3,
    parameter int NUM_REQ     = 4,
    parameter int MUL_LATENCY = 1
) (
    input  logic                       CLK,
    input  logic                       RSTN,
    input  logic [NUM_REQ-1:0]         REQ_VALID,
    output logic [NUM_REQ-1:0]         REQ_READY,
    input  logic [NUM_REQ-1:0]         REQ_OP,
    input  logic [NUM_REQ*WIDTH-1:0]   REQ_A,
    input  logic [NUM_REQ*WIDTH-1:0]   REQ_B,
    output logic [NUM_REQ-1:0]         RSP_VALID,
    output logic [NUM_REQ*WIDTH-1:0]   RSP_VALUE,
    output logic [WIDTH-1:0]           MUL_A_O,
    output logic [WIDTH-1:0]           MUL_B_O,
    output logic                       MUL_VALID_OUT_O,
    input  logic [WIDTH-1:0]           MUL_VALUE_IN_I,
    input  logic                       MUL_VALID_IN_I,
    output logic                       ERROR
);

    localparam int IDX_W   = $clog2(NUM_REQ);
    localparam int GUARD_W = $clog2(MUL_LATENCY + 1);

    localparam logic [WIDTH-1:0] POS_ONE = WIDTH'(1) << FRAC_BITS;
    localparam logic [WIDTH-1:0] NEG_ONE = ~(POS_ONE - 1'b1);

    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   cand_idx;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_any;
    logic [WIDTH-1:0]   sel_a;
    logic [WIDTH-1:0]   sel_b;
    logic               sel_op;
    logic [WIDTH-1:0]   issue_b;
    logic [IDX_W-1:0]   issue_idx;

    logic [MUL_LATENCY-1:0] tag_valid;
    logic [IDX_W-1:0]       tag_idx [MUL_LATENCY];
    logic                   head_valid;
    logic [IDX_W-1:0]       head_idx;

    logic [GUARD_W-1:0]     guard_cnt;
    logic                   guard_done;

    // Search upward from the pointer, wrapping modulo NUM_REQ; first valid requester wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand_idx  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand_idx = IDX_W'((32'(ptr) + k) % NUM_REQ);
            if (!grant_any && REQ_VALID[cand_idx]) begin
                grant_any = 1'b1;
                grant_idx = cand_idx;
            end
        end
    end

    always_comb begin
        REQ_READY = '0;
        if (grant_any && RSTN) begin
            REQ_READY[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        sel_a   = REQ_A[grant_idx*WIDTH +: WIDTH];
        sel_b   = REQ_B[grant_idx*WIDTH +: WIDTH];
        sel_op  = REQ_OP[grant_idx];
        issue_b = sel_op ? (sel_a[WIDTH-1] ? NEG_ONE : POS_ONE) : sel_b;
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            ptr <= '0;
        end else if (grant_any) begin
            ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            MUL_VALID_OUT_O <= 1'b0;
            MUL_A_O         <= '0;
            MUL_B_O         <= '0;
            issue_idx       <= '0;
        end else begin
            MUL_VALID_OUT_O <= grant_any;
            issue_idx       <= grant_idx;
            if (grant_any) begin
                MUL_A_O <= sel_a;
                MUL_B_O <= issue_b;
            end
        end
    end

    // Stage 0 is loaded from the issue register, so the head lines up with the multiplier return.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            tag_valid <= '0;
            for (int unsigned k = 0; k < MUL_LATENCY; k++) begin
                tag_idx[k] <= '0;
            end
        end else begin
            tag_valid[0] <= MUL_VALID_OUT_O;
            tag_idx[0]   <= issue_idx;
            for (int unsigned k = 1; k < MUL_LATENCY; k++) begin
                tag_valid[k] <= tag_valid[k-1];
                tag_idx[k]   <= tag_idx[k-1];
            end
        end
    end

    assign head_valid = tag_valid[MUL_LATENCY-1];
    assign head_idx   = tag_idx[MUL_LATENCY-1];

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            RSP_VALID <= '0;
            RSP_VALUE <= '0;
        end else begin
            RSP_VALID <= '0;
            if (MUL_VALID_IN_I && head_valid) begin
                RSP_VALID[head_idx]                  <= 1'b1;
                RSP_VALUE[head_idx*WIDTH +: WIDTH]   <= MUL_VALUE_IN_I;
            end
        end
    end

    // Results from operations launched before reset may still drain out of the multiplier.
    assign guard_done = (guard_cnt == GUARD_W'(MUL_LATENCY));

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            guard_cnt <= '0;
            ERROR     <= 1'b0;
        end else begin
            if (!guard_done) begin
                guard_cnt <= guard_cnt + 1'b1;
            end
            if (guard_done && (MUL_VALID_IN_I != head_valid)) begin
                ERROR <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fixed_point_mul_arbiter.sv
// Scoreboard bench for fixed_point_mul_arbiter: directed vectors queue expected launches and
// responses; a negedge monitor pops and compares whenever the DUT presents them.
module tb_fixed_point_mul_arbiter;

    localparam int W = 8;
    localparam int F = 3;
    localparam int N = 4;
    localparam int L = 1;

    logic           CLK = 1'b0;
    logic           RSTN = 1'b1;
    logic [N-1:0]   REQ_VALID = '0;
    logic [N-1:0]   REQ_OP = '0;
    logic [N*W-1:0] REQ_A = '0;
    logic [N*W-1:0] REQ_B = '0;
    logic [N-1:0]   REQ_READY;
    logic [N-1:0]   RSP_VALID;
    logic [N*W-1:0] RSP_VALUE;
    logic [W-1:0]   MUL_A_O;
    logic [W-1:0]   MUL_B_O;
    logic           MUL_VALID_OUT_O;
    logic [W-1:0]   mul_val = '0;
    logic           mul_vld = 1'b0;
    logic           ERROR;
    logic           inject = 1'b0;

    typedef struct { logic op; logic [W-1:0] a; logic [W-1:0] b; logic [W-1:0] mb; logic [W-1:0] res; } vec_t;
    typedef struct { logic [W-1:0] res; int due; } rsp_t;
    typedef struct { logic [W-1:0] a; logic [W-1:0] mb; int due; } lch_t;

    vec_t stim_q [N][$];
    rsp_t exp_q [N][$];
    lch_t launch_q [$];
    int   exp_grant [$];

    int cyc   = 0;
    int n_cmp = 0;
    int n_mis = 0;

    fixed_point_mul_arbiter #(
        .WIDTH(W), .FRAC_BITS(F), .NUM_REQ(N), .MUL_LATENCY(L)
    ) dut (
        .CLK(CLK), .RSTN(RSTN),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_OP(REQ_OP),
        .REQ_A(REQ_A), .REQ_B(REQ_B),
        .RSP_VALID(RSP_VALID), .RSP_VALUE(RSP_VALUE),
        .MUL_A_O(MUL_A_O), .MUL_B_O(MUL_B_O), .MUL_VALID_OUT_O(MUL_VALID_OUT_O),
        .MUL_VALUE_IN_I(mul_val), .MUL_VALID_IN_I(mul_vld),
        .ERROR(ERROR)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // Stand-in for the shared multiplier: signed Q(W-F).F product, truncated, one-cycle latency.
    function automatic logic [W-1:0] mul_model(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [2*W-1:0] p;
        p = $signed(a) * $signed(b);
        return p[W-1+F:F];
    endfunction

    always @(posedge CLK) begin
        mul_vld <= MUL_VALID_OUT_O | inject;
        mul_val <= mul_model(MUL_A_O, MUL_B_O);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic add(input int r, input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] mb, input logic [W-1:0] res);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.mb = mb; v.res = res;
        stim_q[r].push_back(v);
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            if (stim_q[i].size() > 0) begin
                REQ_VALID[i]      = 1'b1;
                REQ_OP[i]         = stim_q[i][0].op;
                REQ_A[i*W +: W]   = stim_q[i][0].a;
                REQ_B[i*W +: W]   = stim_q[i][0].b;
            end else begin
                REQ_VALID[i] = 1'b0;
            end
        end
    endtask

    task automatic cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic run(input int budget);
        int n;
        int g;
        vec_t v;
        rsp_t r;
        lch_t l;
        logic [N-1:0] exp_rdy;
        n = 0;
        forever begin
            drive_inputs();
            if (REQ_VALID == '0) break;
            if (n >= budget) begin
                check("run_budget", 1, 0);
                for (int i = 0; i < N; i++) stim_q[i].delete();
                REQ_VALID = '0;
                break;
            end
            #1;
            exp_rdy = '0;
            if (exp_grant.size() == 0) check("grant_list_empty", 1, 0);
            else exp_rdy = N'(1) << exp_grant.pop_front();
            check("grant", REQ_READY, exp_rdy);
            g = -1;
            for (int i = N - 1; i >= 0; i--) if (REQ_READY[i] && REQ_VALID[i]) g = i;
            if (g >= 0) begin
                v = stim_q[g].pop_front();
                r.res = v.res; r.due = cyc + 3;
                exp_q[g].push_back(r);
                l.a = v.a; l.mb = v.mb; l.due = cyc + 1;
                launch_q.push_back(l);
            end
            cycle();
            n++;
        end
    endtask

    task automatic idle(input int n);
        REQ_VALID = '0;
        repeat (n) begin
            #1;
            check("idle_ready", REQ_READY, 0);
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic drain();
        idle(5);
        for (int i = 0; i < N; i++) check("drain_rsp_queue", exp_q[i].size(), 0);
        check("drain_launch_queue", launch_q.size(), 0);
        check("drain_grant_list", exp_grant.size(), 0);
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, {REQ_READY, RSP_VALID, RSP_VALUE, MUL_A_O, MUL_B_O, MUL_VALID_OUT_O, ERROR}, 0);
    endtask

    lch_t mon_l;
    rsp_t mon_r;

    always @(negedge CLK) begin
        if (RSTN) begin
            if (MUL_VALID_OUT_O) begin
                if (launch_q.size() == 0) check("launch_unexpected", 1, 0);
                else begin
                    mon_l = launch_q.pop_front();
                    check("launch_operands", {MUL_A_O, MUL_B_O}, {mon_l.a, mon_l.mb});
                    check("launch_cycle", cyc, mon_l.due);
                end
            end
            for (int i = 0; i < N; i++) begin
                if (RSP_VALID[i]) begin
                    if (exp_q[i].size() == 0) check("rsp_unexpected", 1, 0);
                    else begin
                        mon_r = exp_q[i].pop_front();
                        check("rsp_value", RSP_VALUE[i*W +: W], mon_r.res);
                        check("rsp_cycle", cyc, mon_r.due);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 RSTN = 1'b0;
        #1 check_reset_outputs("reset_outputs");
        @(posedge CLK);
        @(posedge CLK);
        #2 RSTN = 1'b1;
        cycle();

        // Fairness: all four hold valid for eight grants starting from pointer 0.
        for (int k = 0; k < 2; k++) begin
            add(0, 1'b0, 8'h08, 8'h10, 8'h10, 8'h10);
            add(1, 1'b0, 8'h10, 8'h18, 8'h18, 8'h30);
            add(2, 1'b0, 8'h0C, 8'h0C, 8'h0C, 8'h12);
            add(3, 1'b0, 8'hF0, 8'h0C, 8'h0C, 8'hE8);
        end
        for (int k = 0; k < 8; k++) exp_grant.push_back(k % 4);
        run(20);
        drain();

        // Single MUL from requester 2: 1.5 * 2.0 = 3.0.
        add(2, 1'b0, 8'h0C, 8'h10, 8'h10, 8'h18);
        exp_grant.push_back(2);
        run(5);
        drain();

        // Pointer at 3, requesters 1 and 3 valid: 3 then 1, pointer ends at 2.
        add(1, 1'b0, 8'h08, 8'h08, 8'h08, 8'h08);
        add(3, 1'b0, 8'h04, 8'h04, 8'h04, 8'h02);
        exp_grant.push_back(3);
        exp_grant.push_back(1);
        run(5);
        drain();
        add(0, 1'b0, 8'h18, 8'hF8, 8'hF8, 8'hE8);
        add(2, 1'b0, 8'h14, 8'h08, 8'h08, 8'h14);
        exp_grant.push_back(2);
        exp_grant.push_back(0);
        run(5);
        drain();

        // ABS both signs on requester 0 plus most-negative on requester 3; B is ignored.
        add(0, 1'b1, 8'hF4, 8'h55, 8'hF8, 8'h0C);
        add(0, 1'b1, 8'h0C, 8'hAA, 8'h08, 8'h0C);
        add(3, 1'b1, 8'h80, 8'h3C, 8'hF8, 8'h80);
        exp_grant.push_back(3);
        exp_grant.push_back(0);
        exp_grant.push_back(0);
        run(6);
        drain();

        // Result with no operation in flight.
        check("error_before_orphan", ERROR, 0);
        inject = 1'b1;
        cycle();
        inject = 1'b0;
        check("orphan_present", mul_vld, 1);
        cycle();
        check("error_set", ERROR, 1);
        idle(3);
        check("error_sticky", ERROR, 1);
        drain();

        // Reset between issue and return; late result must vanish silently.
        add(1, 1'b0, 8'h08, 8'h10, 8'h10, 8'h10);
        exp_grant.push_back(1);
        run(5);
        check("issue_before_reset", MUL_VALID_OUT_O, 1);
        #1 RSTN = 1'b0;
        inject = 1'b1;
        #1 check_reset_outputs("reset_midflight_outputs");
        launch_q.delete();
        for (int i = 0; i < N; i++) exp_q[i].delete();
        cycle();
        inject = 1'b0;
        check("late_result_present", mul_vld, 1);
        #1 RSTN = 1'b1;
        @(posedge CLK);
        #1;
        check("late_rsp_valid", RSP_VALID, 0);
        check("late_error", ERROR, 0);
        idle(4);
        check("late_error_hold", ERROR, 0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/fixed_point_mul_arbiter.md
Name: fixed_point_mul_arbiter

Overview:
- Shares one external fixed-point multiplier between NUM_REQ requesters using round-robin arbitration.
- Each request is either MUL (A*B) or ABS (|A|). ABS is issued to the multiplier as A*(+1.0) or A*(-1.0), so every request sees the same latency and ordering.
- A tag pipeline records which requester each in-flight operation belongs to, and each result is routed back to that requester's registered response port.
- Sits between the neuron/activation datapath clients and the single shared multiplier instance.

Parameters:
- WIDTH, 8, data width of all fixed-point operands and results.
- FRAC_BITS, 3, number of fractional bits.
- NUM_REQ, 4, number of requesters; minimum 2.
- MUL_LATENCY, 1, fixed cycles from MUL_VALID_OUT_O launch to MUL_VALID_IN_I return; minimum 1.

Ports:
- CLK  in  1  clock.
- RSTN  in  1  asynchronous active-low reset.
- REQ_VALID  in  NUM_REQ  per-requester request valid.
- REQ_READY  out  NUM_REQ  per-requester grant; a transfer occurs when valid and ready are both high.
- REQ_OP  in  NUM_REQ  per-requester opcode: 0 = MUL, 1 = ABS.
- REQ_A  in  NUM_REQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- REQ_B  in  NUM_REQ*WIDTH  operand B; ignored for ABS.
- RSP_VALID  out  NUM_REQ  one-cycle result pulse per requester.
- RSP_VALUE  out  NUM_REQ*WIDTH  registered result per requester.
- MUL_A_O  out  WIDTH  operand A to the shared multiplier.
- MUL_B_O  out  WIDTH  operand B to the shared multiplier.
- MUL_VALID_OUT_O  out  1  launch strobe to the multiplier.
- MUL_VALUE_IN_I  in  WIDTH  multiplier result.
- MUL_VALID_IN_I  in  1  multiplier result valid.
- ERROR  out  1  sticky flag: result/tag mismatch.

Behaviour:
- Reset (RSTN low, asynchronous): the following clear immediately.
  - REQ_READY, RSP_VALID, RSP_VALUE, MUL_A_O, MUL_B_O, MUL_VALID_OUT_O and ERROR go to 0.
  - The round-robin pointer resets to 0.
  - The tag pipeline is flushed to empty.
- Reset mid-operation: in-flight results that arrive after reset release find no tag. They are discarded and must not set ERROR during the first MUL_LATENCY cycles after release.
- Arbitration (combinational):
  - The grant goes to the first requester with REQ_VALID set, searching upward from the pointer and wrapping modulo NUM_REQ.
  - At most one REQ_READY bit is high per cycle.
  - REQ_READY is 0 for every requester when no request is valid.
  - A requester must hold its valid and operands stable until granted.
- Pointer update: on a grant to requester g, the pointer becomes (g+1) mod NUM_REQ. The pointer does not change in cycles without a grant.
- Issue (registered, one cycle after the grant):
  - MUL_VALID_OUT_O=1 and MUL_A_O=A.
  - MUL: MUL_B_O=B.
  - ABS: MUL_B_O is +1.0 when A[WIDTH-1]=0, else -1.0.
    - +1.0 means bit FRAC_BITS set and all other bits 0.
    - -1.0 means bits [WIDTH-1:FRAC_BITS] all 1 and bits [FRAC_BITS-1:0] all 0.
  - One issue per cycle maximum, so sustained throughput is one op per clock.
- Tag pipeline:
  - A MUL_LATENCY-deep shift register of {tag_valid, requester index} advances every cycle, in step with MUL_VALID_OUT_O.
  - On MUL_VALID_IN_I=1 with the pipeline-head tag_valid=1, the result goes to requester idx on the next clock edge: RSP_VALUE[idx] is updated and RSP_VALID[idx] pulses for 1 cycle.
  - RSP_VALUE slices of other requesters hold their previous value.
- Total latency, grant to RSP_VALID: MUL_LATENCY+2 cycles. The components are the issue register, MUL_LATENCY, and the response register.
- Mismatch: if MUL_VALID_IN_I differs from the head tag_valid, ERROR is set and stays set until reset. A result with no tag is dropped. A tag with no result produces no response.
- ABS of the most negative value (1 followed by zeros) returns whatever the multiplier produces. No saturation is added here.
- Simultaneous events: a grant, an issue and a response for different operations complete in the same cycle without stalls.

Test Plan:
1. Single MUL: WIDTH=8, FRAC=3, MUL_LATENCY=1. Requester 2 sends A=0x0C (1.5), B=0x10 (2.0) → MUL_A_O=0x0C, MUL_B_O=0x10 one cycle after the grant; RSP_VALID[2] pulses with RSP_VALUE[2]=0x18 three cycles after the grant; other RSP_VALID bits stay 0.
2. ABS both signs: requester 0 sends A=0xF4 (-1.5), then A=0x0C → MUL_B_O is 0xF8 and then 0x08; both responses on requester 0 equal 0x0C, one cycle apart.
3. Round-robin fairness: all 4 REQ_VALID held high for 8 cycles → grant order 0,1,2,3,0,1,2,3; one REQ_READY bit high per cycle; 8 responses, each routed to the correct requester.
4. Sparse contention and wrap: pointer at 3, requesters 1 and 3 valid → requester 3 is granted, then requester 1; the pointer becomes 2.
5. Mismatch: inject MUL_VALID_IN_I=1 while no operation is in flight → ERROR goes to 1 and stays; no RSP_VALID pulse.
6. Async reset mid-flight: assert RSTN low between issue and return → all outputs are 0 immediately with no clock edge; the late result after release causes no RSP_VALID and no ERROR.
